// File: rtl/prbs15_byte_checker_pkg.sv
// Shared PRBS-15 definitions: FSM state encoding, polynomial taps and the byte step function.
package prbs_pkg;

  localparam int PRBS_LEN = 15;
  localparam int TAP_A    = 14;
  localparam int TAP_B    = 13;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    PAT   = 2'd1,
    SEED  = 2'd2,
    CHECK = 2'd3
  } state_e;

  // Eight Fibonacci steps of x^15+x^14+1; the first generated bit lands in bit 7.
  function automatic logic [PRBS_LEN+7:0] prbs15_next8(input logic [PRBS_LEN-1:0] lfsr);
    logic [PRBS_LEN-1:0] s;
    logic [7:0]          byte_v;
    logic                b;
    s      = lfsr;
    byte_v = '0;
    for (int i = 0; i < 8; i++) begin
      b      = s[TAP_A] ^ s[TAP_B];
      s      = {s[PRBS_LEN-2:0], b};
      byte_v = {byte_v[6:0], b};
    end
    return {s, byte_v};
  endfunction

endpackage

// File: rtl/prbs15_byte_checker_lfsr.sv
// PRBS-15 byte LFSR: parallel load, shift-in of a received byte for seeding, or one-byte advance.
module prbs15_byte_lfsr
  import prbs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [PRBS_LEN-1:0] load_val_i,
  input  logic                shift_in_i,
  input  logic                advance_i,
  input  logic [7:0]          data_i,
  output logic [PRBS_LEN-1:0] seed_o,
  output logic [7:0]          byte_o
);

  logic [PRBS_LEN-1:0] lfsr_q, lfsr_d, step_lfsr;

  always_comb begin
    {step_lfsr, byte_o} = prbs15_next8(lfsr_q);
  end

  // Register value if data_i were shifted in: the last 15 stream bits.
  assign seed_o = {lfsr_q[PRBS_LEN-9:0], data_i};

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)          lfsr_d = load_val_i;
    else if (shift_in_i) lfsr_d = seed_o;
    else if (advance_i)  lfsr_d = step_lfsr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/prbs15_byte_checker.sv
// PRBS-15 byte checker: frame hunt, self-seeding and bit-error counting.
// Define PRBS_CHK_RESYNC_EN to drop lock after LOSS_THRESH consecutive errored bytes.
module prbs15_byte_checker
  import prbs_pkg::*;
#(
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic [1:0]       n,
  input  logic [31:0]      pattern,
  input  logic             err_clr,
  output logic             pattern_ok,
  output logic             prbs_lock,
  output logic             byte_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_o
);

  if (LOSS_THRESH < 1) begin : g_bad_thresh
    $error("LOSS_THRESH must be at least 1");
  end

  state_e              state_q, state_d;
  logic [1:0]          idx_q, idx_d, rep_q, rep_d, n_q;
  logic                pat_ok_q, pat_ok_d, lock_q, lock_d, berr_q, berr_d;
  logic [ERR_W-1:0]    cnt_q, cnt_d;
  logic                shift_in, advance;
  logic [PRBS_LEN-1:0] seed;
  logic [7:0]          exp_byte, diff, pat_byte;
  logic [3:0]          bit_errs;
  logic [ERR_W:0]      sum;
`ifdef PRBS_CHK_RESYNC_EN
  localparam int LOSS_W = $clog2(LOSS_THRESH + 1);
  logic [LOSS_W-1:0]   loss_q, loss_d;
`endif

  prbs15_byte_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (1'b0),
    .load_val_i('0),
    .shift_in_i(shift_in),
    .advance_i (advance),
    .data_i    (data_in),
    .seed_o    (seed),
    .byte_o    (exp_byte)
  );

  always_comb begin
    case (idx_q)
      2'd0:    pat_byte = pattern[31:24];
      2'd1:    pat_byte = pattern[23:16];
      2'd2:    pat_byte = pattern[15:8];
      default: pat_byte = pattern[7:0];
    endcase
  end

  always_comb begin
    diff     = data_in ^ exp_byte;
    bit_errs = '0;
    for (int i = 0; i < 8; i++) bit_errs = bit_errs + {3'b000, diff[i]};
  end

  assign sum = {1'b0, cnt_q} + {{(ERR_W-3){1'b0}}, bit_errs};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rep_d    = rep_q;
    pat_ok_d = 1'b0;
    berr_d   = 1'b0;
    lock_d   = lock_q;
    cnt_d    = cnt_q;
    shift_in = 1'b0;
    advance  = 1'b0;
`ifdef PRBS_CHK_RESYNC_EN
    loss_d   = loss_q;
`endif
    if (data_valid) begin
      case (state_q)
        HUNT: begin
          rep_d = 2'd0;
          if (n == 2'd0) begin
            // This byte is the first half of the seed; SEED then needs one more.
            shift_in = 1'b1;
            idx_d    = 2'd1;
            state_d  = SEED;
          end else if (data_in == pattern[31:24]) begin
            idx_d   = 2'd1;
            state_d = PAT;
          end else begin
            idx_d = 2'd0;
          end
        end
        PAT: begin
          if (data_in == pat_byte) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              rep_d = rep_q + 2'd1;
              if (rep_q + 2'd1 == n_q) begin
                pat_ok_d = 1'b1;
                rep_d    = 2'd0;
                idx_d    = 2'd0;
                state_d  = SEED;
              end
            end
          end else begin
            rep_d = 2'd0;
            if (data_in == pattern[31:24]) begin
              idx_d = 2'd1;
            end else begin
              idx_d   = 2'd0;
              state_d = HUNT;
            end
          end
        end
        SEED: begin
          shift_in = 1'b1;
          if (idx_q == 2'd1) begin
            idx_d = 2'd0;
            if (seed == '0) begin
              state_d = HUNT;
            end else begin
              state_d = CHECK;
              lock_d  = 1'b1;
            end
          end else begin
            idx_d = 2'd1;
          end
        end
        default: begin
          advance = 1'b1;
          berr_d  = (bit_errs != 4'd0);
          cnt_d   = sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
`ifdef PRBS_CHK_RESYNC_EN
          if (bit_errs != 4'd0) begin
            if (loss_q == LOSS_W'(LOSS_THRESH - 1)) begin
              loss_d  = '0;
              lock_d  = 1'b0;
              state_d = HUNT;
            end else begin
              loss_d = loss_q + 1'b1;
            end
          end else begin
            loss_d = '0;
          end
`else
          // Without resync, CHECK holds until reset.
`endif
        end
      endcase
    end
    if (err_clr) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= HUNT;
      idx_q    <= 2'd0;
      rep_q    <= 2'd0;
      n_q      <= 2'd0;
      pat_ok_q <= 1'b0;
      lock_q   <= 1'b0;
      berr_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef PRBS_CHK_RESYNC_EN
      loss_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rep_q    <= rep_d;
      if (state_q == HUNT) n_q <= n;
      pat_ok_q <= pat_ok_d;
      lock_q   <= lock_d;
      berr_q   <= berr_d;
      cnt_q    <= cnt_d;
`ifdef PRBS_CHK_RESYNC_EN
      loss_q   <= loss_d;
`endif
    end
  end

  assign pattern_ok = pat_ok_q;
  assign prbs_lock  = lock_q;
  assign byte_err   = berr_q;
  assign err_cnt    = cnt_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_prbs15_byte_checker.sv
// Scoreboard bench for prbs15_byte_checker: directed frames, seeding, error injection, resets.
`timescale 1ns/1ps
module tb_prbs15_byte_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [1:0]  n;
  logic [31:0] pattern;
  logic        err_clr;
  logic        pattern_ok, prbs_lock, byte_err;
  logic [15:0] err_cnt;
  logic [1:0]  state_o;

  prbs15_byte_checker #(.ERR_W(16), .LOSS_THRESH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_valid(data_valid),
    .n         (n),
    .pattern   (pattern),
    .err_clr   (err_clr),
    .pattern_ok(pattern_ok),
    .prbs_lock (prbs_lock),
    .byte_err  (byte_err),
    .err_cnt   (err_cnt),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pok;
    logic        lock;
    logic        berr;
    logic [15:0] cnt;
    logic [1:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        acc = 1'b0;
  logic [14:0] tx_s;
  logic [15:0] cnt_m;
  logic [7:0]  b;
  exp_t        mon_e, mon_g;
  string       mon_t;

  function automatic exp_t mk(input logic pok, input logic lock, input logic berr,
                              input logic [15:0] cnt, input logic [1:0] st);
    exp_t e;
    e.pok = pok; e.lock = lock; e.berr = berr; e.cnt = cnt; e.st = st;
    return e;
  endfunction

  // Transmitter model: bit-serial x^15+x^14+1, first bit out is bit 7.
  task automatic tx_next(output logic [7:0] bo);
    logic bit_v;
    bo = '0;
    for (int i = 0; i < 8; i++) begin
      bit_v = tx_s[14] ^ tx_s[13];
      tx_s  = {tx_s[13:0], bit_v};
      bo    = {bo[6:0], bit_v};
    end
  endtask

  task automatic send(input logic [7:0] d, input logic clr, input exp_t e, input string tag);
    data_in    = d;
    data_valid = 1'b1;
    err_clr    = clr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    data_valid = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
    @(posedge clk); #1;
  endtask

  // Raise rst between edges; outputs must clear without waiting for a clock.
  task automatic chk_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({pattern_ok, prbs_lock, byte_err, err_cnt, state_o} !== 21'd0) begin
      n_bad++;
      $display("FAIL %s: got pok=%0b lock=%0b berr=%0b cnt=%h st=%0d, required all zero",
               tag, pattern_ok, prbs_lock, byte_err, err_cnt, state_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  always @(posedge clk) acc <= data_valid && !rst;

  always @(negedge clk) begin
    mon_g = {pattern_ok, prbs_lock, byte_err, err_cnt, state_o};
    if (acc) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_response: got st=%0d, required no response", state_o);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        if (mon_g !== mon_e) begin
          n_bad++;
          $display("FAIL %s: got pok=%0b lock=%0b berr=%0b cnt=%h st=%0d, required pok=%0b lock=%0b berr=%0b cnt=%h st=%0d",
                   mon_t, mon_g.pok, mon_g.lock, mon_g.berr, mon_g.cnt, mon_g.st,
                   mon_e.pok, mon_e.lock, mon_e.berr, mon_e.cnt, mon_e.st);
        end
      end
    end else begin
      n_cmp++;
      if (pattern_ok !== 1'b0 || byte_err !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_pulse: got pok=%0b berr=%0b, required 0 0", pattern_ok, byte_err);
      end
    end
  end

  initial begin
    logic [7:0] t1 [8];
    logic [7:0] t4 [6];
    t1 = '{8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    t4 = '{8'hCC, 8'hDD, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    data_valid = 1'b0; err_clr = 1'b0; data_in = 8'h00;
    n = 2'd2; pattern = 32'hCCDDEEFF;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pattern_ok, prbs_lock, byte_err, err_cnt, state_o} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset: got st=%0d cnt=%h lock=%0b, required all zero", state_o, err_cnt, prbs_lock);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Two repetitions of CC DD EE FF; pulse only after the eighth byte.
    for (int i = 0; i < 8; i++)
      send(t1[i], 1'b0, mk(i == 7, 1'b0, 1'b0, 16'h0, (i == 7) ? 2'd2 : 2'd1), "t1_pattern");

    // Seed from a transmitter started at 7FFF, then clean traffic with gaps.
    tx_s = 15'h7FFF;
    tx_next(b); send(b, 1'b0, mk(0, 0, 0, 16'h0, 2'd2), "t2_seed0");
    tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'h0, 2'd3), "t2_seed1");
    for (int i = 0; i < 100; i++) begin
      tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'h0, 2'd3), "t2_clean");
      if (i % 17 == 5) idle(2);
    end

    tx_next(b); send(b ^ 8'h81, 1'b0, mk(0, 1, 1, 16'd2, 2'd3), "t3_err81");
    for (int i = 0; i < 5; i++) begin
      tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'd2, 2'd3), "t3_after");
    end

    tx_next(b); send(b ^ 8'h10, 1'b1, mk(0, 1, 1, 16'd0, 2'd3), "t5_clr_wins");
    for (int i = 0; i < 3; i++) begin
      tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'd0, 2'd3), "t5_after_clr");
    end

    cnt_m = 16'd0;
    for (int i = 0; i < 4; i++) begin
      tx_next(b);
      cnt_m = cnt_m + 16'd1;
`ifdef PRBS_CHK_RESYNC_EN
      send(b ^ 8'h01, 1'b0, (i == 3) ? mk(0, 0, 1, cnt_m, 2'd0) : mk(0, 1, 1, cnt_m, 2'd3), "t6_loss");
`else
      send(b ^ 8'h01, 1'b0, mk(0, 1, 1, cnt_m, 2'd3), "t6_lock_holds");
`endif
    end

`ifndef PRBS_CHK_RESYNC_EN
    // Fully inverted bytes add 8 each until the counter pins at FFFF.
    for (int i = 0; i < 8200; i++) begin
      tx_next(b);
      cnt_m = (cnt_m > 16'hFFF7) ? 16'hFFFF : cnt_m + 16'd8;
      send(b ^ 8'hFF, 1'b0, mk(0, 1, 1, cnt_m, 2'd3), "t5_saturate");
    end
    tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'hFFFF, 2'd3), "t5_sat_hold");
    tx_next(b); send(b, 1'b1, mk(0, 1, 0, 16'h0, 2'd3), "t5_sat_clear");
`endif
    drain();
    chk_rst("rst_from_check");

    // n=1: a mismatch on a first-pattern byte restarts at index 1.
    n = 2'd1;
    idle(1);
    for (int i = 0; i < 6; i++)
      send(t4[i], 1'b0, mk(i == 5, 1'b0, 1'b0, 16'h0, (i == 5) ? 2'd2 : 2'd1), "t4_restart");
    drain();
    chk_rst("rst_from_seed");

    // n=0 seeds directly; an all-zero seed is rejected.
    n = 2'd0;
    idle(1);
    send(8'h00, 1'b0, mk(0, 0, 0, 16'h0, 2'd2), "seed0_first");
    send(8'h00, 1'b0, mk(0, 0, 0, 16'h0, 2'd0), "seed0_reject");
    tx_s = 15'h1234;
    tx_next(b); send(b, 1'b0, mk(0, 0, 0, 16'h0, 2'd2), "n0_seed0");
    tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'h0, 2'd3), "n0_seed1");
    for (int i = 0; i < 5; i++) begin
      tx_next(b); send(b, 1'b0, mk(0, 1, 0, 16'h0, 2'd3), "n0_clean");
    end
    tx_next(b); send(b ^ 8'h80, 1'b0, mk(0, 1, 1, 16'd1, 2'd3), "n0_err80");
    drain();
    chk_rst("rst_from_n0");

    n = 2'd2;
    idle(1);
    send(8'hCC, 1'b0, mk(0, 0, 0, 16'h0, 2'd1), "pat_enter");
    send(8'hDD, 1'b0, mk(0, 0, 0, 16'h0, 2'd1), "pat_second");
    idle(2);
    drain();
    chk_rst("rst_mid_pat");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
